cpu_bus_master: RTL and testbench

//  Sequencing successor to the combinational CPU-to-NuBus encoder. Claims CPU requests at or above a

---
 rtl/cpu_bus_pkg.sv | 38 +++
 rtl/cpu_bus_encoder.sv | 24 ++
 rtl/cpu_bus_master.sv | 191 +++++++++++++++++++
 tb/tb_cpu_bus_master.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_bus_pkg.sv
// Shared types for the CPU-to-NuBus master: FSM states, ACK status codes and the
// byte-strobe to TM/AD lane encoder.
package cpu_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ARB  = 3'd1,
    ST_ADDR = 3'd2,
    ST_DATA = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  // Slave status is the inverted {TM1*,TM0*} pair sampled with ACK*.
  typedef enum logic [1:0] {
    ST_COMPLETE = 2'b00,
    ST_ERROR    = 2'b01,
    ST_TIMEOUT  = 2'b10,
    ST_RETRY    = 2'b11
  } status_e;

  // Returns {err,tm1n,tm0n,ad1n,ad0n}; err flags a strobe pattern NuBus cannot express.
  function automatic logic [4:0] tmadn_encode(input logic [3:0] strb);
    logic [4:0] r;
    case (strb)
      4'b0000: r = 5'b01111;
      4'b0001: r = 5'b00011;
      4'b0010: r = 5'b00010;
      4'b0011: r = 5'b00110;
      4'b0100: r = 5'b00001;
      4'b1000: r = 5'b00000;
      4'b1100: r = 5'b00100;
      4'b1111: r = 5'b00111;
      default: r = 5'b10000;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cpu_bus_encoder.sv
// Combinational lane encoder: maps CPU byte strobes onto NuBus TM*/AD[1:0] and
// builds the address-cycle AD word.
module cpu_bus_encoder
  import cpu_bus_pkg::*;
(
  input  logic [3:0]  strb,
  input  logic [29:0] word_addr,
  output logic        illegal,
  output logic        tm1n,
  output logic        tm0n,
  output logic [31:0] addr_ad
);

  logic [4:0] tmadn;

  always_comb begin
    tmadn   = tmadn_encode(strb);
    illegal = tmadn[4];
    tm1n    = tmadn[3];
    tm0n    = tmadn[2];
    addr_ad = {word_addr, ~tmadn[1:0]};
  end

endmodule

// File: rtl/cpu_bus_master.sv
// CPU-to-NuBus bus master: claims windowed CPU requests, arbitrates, runs the
// address/data cycles and returns a one-cycle ready with data or error.
module cpu_bus_master
  import cpu_bus_pkg::*;
#(
  parameter logic [3:0] NUBUS_CONTROLLER_ADDR_START = 4'h6,
  parameter int         TIMEOUT_CYCLES              = 255,
  parameter int         MAX_RETRY                   = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_valid,
  input  logic [3:0]  cpu_write,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_ready,
  output logic [31:0] cpu_rdata,
  output logic        cpu_error,
  output logic        cpu_masterd_o,
  output logic        arb_req_o,
  input  logic        arb_grant_i,
  output logic        nub_startn_o,
  output logic [31:0] nub_ad_o,
  output logic        nub_ad_oe,
  output logic        nub_tm1n_o,
  output logic        nub_tm0n_o,
  input  logic [31:0] nub_ad_i,
  input  logic        nub_ackn_i,
  input  logic        nub_tm1n_i,
  input  logic        nub_tm0n_i
);

  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int RW = $clog2(MAX_RETRY + 1) + 1;

  state_e      state_q, state_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [RW-1:0] retry_q, retry_d;
  logic        drop_q, drop_d;
  logic        err_q, err_d;
  logic        wr_q, wr_d;
  logic        tm1n_q, tm1n_d;
  logic        tm0n_q, tm0n_d;
  logic [31:0] ad_q, ad_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;

  logic        enc_illegal, enc_tm1n, enc_tm0n;
  logic [31:0] enc_ad;
  logic        claimed;
  status_e     status;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^cpu_addr[1:0];

  cpu_bus_encoder u_enc (
    .strb      (cpu_write),
    .word_addr (cpu_addr[31:2]),
    .illegal   (enc_illegal),
    .tm1n      (enc_tm1n),
    .tm0n      (enc_tm0n),
    .addr_ad   (enc_ad)
  );

  assign claimed       = cpu_valid && (cpu_addr[31:28] >= NUBUS_CONTROLLER_ADDR_START);
  assign cpu_masterd_o = claimed;
  assign status        = status_e'(~{nub_tm1n_i, nub_tm0n_i});

  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    retry_d = retry_q;
    drop_d  = drop_q;
    err_d   = err_q;
    wr_d    = wr_q;
    tm1n_d  = tm1n_q;
    tm0n_d  = tm0n_q;
    ad_d    = ad_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (claimed) begin
          wr_d    = |cpu_write;
          tm1n_d  = enc_tm1n;
          tm0n_d  = enc_tm0n;
          ad_d    = enc_ad;
          wdata_d = cpu_wdata;
          retry_d = '0;
          drop_d  = 1'b0;
          if (enc_illegal) begin
            err_d   = 1'b1;
            rdata_d = '0;
            state_d = ST_DONE;
          end else begin
            err_d   = 1'b0;
            state_d = ST_ARB;
          end
        end
      end
      ST_ARB: begin
        // After a retry the request is held low for one cycle before re-arbitrating.
        if (drop_q)           drop_d  = 1'b0;
        else if (arb_grant_i) state_d = ST_ADDR;
      end
      ST_ADDR: begin
        tcnt_d  = '0;
        state_d = ST_DATA;
      end
      ST_DATA: begin
        tcnt_d = tcnt_q + 1'b1;
        if (!nub_ackn_i) begin
          case (status)
            ST_COMPLETE: begin
              err_d   = 1'b0;
              if (!wr_q) rdata_d = nub_ad_i;
              state_d = ST_DONE;
            end
            ST_RETRY: begin
              if (retry_q < RW'(MAX_RETRY)) begin
                retry_d = retry_q + 1'b1;
                drop_d  = 1'b1;
                state_d = ST_ARB;
              end else begin
                err_d   = 1'b1;
                rdata_d = '0;
                state_d = ST_DONE;
              end
            end
            default: begin
              err_d   = 1'b1;
              rdata_d = '0;
              state_d = ST_DONE;
            end
          endcase
        end else if (tcnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      tcnt_q  <= '0;
      retry_q <= '0;
      drop_q  <= 1'b0;
      err_q   <= 1'b0;
      wr_q    <= 1'b0;
      tm1n_q  <= 1'b1;
      tm0n_q  <= 1'b1;
      ad_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      retry_q <= retry_d;
      drop_q  <= drop_d;
      err_q   <= err_d;
      wr_q    <= wr_d;
      tm1n_q  <= tm1n_d;
      tm0n_q  <= tm0n_d;
      ad_q    <= ad_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Bus-side outputs decode straight from state, so reset lands them on idle values.
  always_comb begin
    cpu_ready    = (state_q == ST_DONE);
    cpu_error    = (state_q == ST_DONE) && err_q;
    cpu_rdata    = rdata_q;
    arb_req_o    = ((state_q == ST_ARB) && !drop_q) || (state_q == ST_ADDR) ||
                   (state_q == ST_DATA);
    nub_startn_o = (state_q != ST_ADDR);
    nub_ad_oe    = (state_q == ST_ADDR) || ((state_q == ST_DATA) && wr_q);
    nub_tm1n_o   = (state_q == ST_ADDR) ? tm1n_q : 1'b1;
    nub_tm0n_o   = (state_q == ST_ADDR) ? tm0n_q : 1'b1;
    nub_ad_o     = '0;
    if (state_q == ST_ADDR)             nub_ad_o = ad_q;
    else if (state_q == ST_DATA && wr_q) nub_ad_o = wdata_q;
  end

endmodule

// File: tb/tb_cpu_bus_master.sv
// Directed bench for cpu_bus_master: read, write, illegal strobe, retry, timeout,
// unclaimed address and mid-transaction reset.
module tb_cpu_bus_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_valid;
  logic [3:0]  cpu_write;
  logic [31:0] cpu_addr, cpu_wdata;
  logic        cpu_ready, cpu_error, cpu_masterd_o;
  logic [31:0] cpu_rdata;
  logic        arb_req_o, arb_grant_i;
  logic        nub_startn_o, nub_ad_oe, nub_tm1n_o, nub_tm0n_o;
  logic [31:0] nub_ad_o, nub_ad_i;
  logic        nub_ackn_i, nub_tm1n_i, nub_tm0n_i;

  int checks = 0;
  int failures = 0;

  cpu_bus_master #(
    .NUBUS_CONTROLLER_ADDR_START(4'h6),
    .TIMEOUT_CYCLES(8),
    .MAX_RETRY(3)
  ) dut (
    .clk(clk), .reset(reset),
    .cpu_valid(cpu_valid), .cpu_write(cpu_write), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
    .cpu_error(cpu_error), .cpu_masterd_o(cpu_masterd_o),
    .arb_req_o(arb_req_o), .arb_grant_i(arb_grant_i),
    .nub_startn_o(nub_startn_o), .nub_ad_o(nub_ad_o), .nub_ad_oe(nub_ad_oe),
    .nub_tm1n_o(nub_tm1n_o), .nub_tm0n_o(nub_tm0n_o),
    .nub_ad_i(nub_ad_i), .nub_ackn_i(nub_ackn_i),
    .nub_tm1n_i(nub_tm1n_i), .nub_tm0n_i(nub_tm0n_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [3:0] strb, input logic [31:0] addr, input logic [31:0] wd);
    cpu_valid = 1'b1;
    cpu_write = strb;
    cpu_addr  = addr;
    cpu_wdata = wd;
  endtask

  task automatic idle_bus();
    cpu_valid  = 1'b0;
    nub_ackn_i = 1'b1;
    nub_tm1n_i = 1'b1;
    nub_tm0n_i = 1'b1;
  endtask

  initial begin
    int n;
    int addr_cycles;
    reset = 1'b1; arb_grant_i = 1'b1; nub_ad_i = '0;
    cpu_write = '0; cpu_addr = '0; cpu_wdata = '0;
    idle_bus();
    step(); step();
    reset = 1'b0;
    step();
    chk("rst_ready", cpu_ready, 0);
    chk("rst_err", cpu_error, 0);
    chk("rst_rdata", cpu_rdata, 0);
    chk("rst_arb", arb_req_o, 0);
    chk("rst_startn", nub_startn_o, 1);
    chk("rst_oe", nub_ad_oe, 0);
    chk("rst_tm", {nub_tm1n_o, nub_tm0n_o}, 2'b11);
    chk("rst_ad", nub_ad_o, 0);

    // Read, status 00
    req(4'b0000, 32'h6000_0010, 32'h0);
    #1 chk("rd_masterd", cpu_masterd_o, 1);
    step();
    chk("rd_arb", arb_req_o, 1);
    chk("rd_arb_startn", nub_startn_o, 1);
    step();
    chk("rd_addr_startn", nub_startn_o, 0);
    chk("rd_addr_ad", nub_ad_o, 32'h6000_0010);
    chk("rd_addr_tm", {nub_tm1n_o, nub_tm0n_o}, 2'b11);
    chk("rd_addr_oe", nub_ad_oe, 1);
    nub_ackn_i = 1'b0; nub_tm1n_i = 1'b1; nub_tm0n_i = 1'b1; nub_ad_i = 32'hCAFE_BABE;
    step();
    chk("rd_data_oe", nub_ad_oe, 0);
    chk("rd_data_ready", cpu_ready, 0);
    chk("rd_data_startn", nub_startn_o, 1);
    step();
    chk("rd_ready", cpu_ready, 1);
    chk("rd_rdata", cpu_rdata, 32'hCAFE_BABE);
    chk("rd_err", cpu_error, 0);
    chk("rd_done_arb", arb_req_o, 0);
    idle_bus();
    step();
    chk("rd_ready_pulse", cpu_ready, 0);

    // Write, strobe 0100
    req(4'b0100, 32'h8000_0000, 32'h00AB_0000);
    step(); step();
    chk("wr_addr_ad", nub_ad_o, 32'h8000_0002);
    chk("wr_addr_tm", {nub_tm1n_o, nub_tm0n_o}, 2'b00);
    step();
    chk("wr_data_ad", nub_ad_o, 32'h00AB_0000);
    chk("wr_data_oe", nub_ad_oe, 1);
    nub_ackn_i = 1'b0;
    step();
    chk("wr_ready", cpu_ready, 1);
    chk("wr_err", cpu_error, 0);
    chk("wr_rdata_hold", cpu_rdata, 32'hCAFE_BABE);
    chk("wr_done_oe", nub_ad_oe, 0);
    idle_bus();
    step();

    // Illegal strobe: immediate error, bus untouched
    req(4'b0101, 32'h7000_0000, 32'h0);
    #1 chk("ill_arb0", arb_req_o, 0);
    step();
    chk("ill_ready", cpu_ready, 1);
    chk("ill_err", cpu_error, 1);
    chk("ill_arb1", arb_req_o, 0);
    chk("ill_startn", nub_startn_o, 1);
    chk("ill_rdata", cpu_rdata, 0);
    idle_bus();
    step();
    chk("ill_after", cpu_ready, 0);

    // Retry status 11 on every ACK
    req(4'b0000, 32'h6000_0000, 32'h0);
    nub_ackn_i = 1'b0; nub_tm1n_i = 1'b0; nub_tm0n_i = 1'b0;
    addr_cycles = 0; n = 0;
    while (!cpu_ready && n < 60) begin
      step();
      n++;
      if (!nub_startn_o) addr_cycles++;
    end
    chk("rty_done", cpu_ready, 1);
    chk("rty_addr_cycles", addr_cycles, 4);
    chk("rty_err", cpu_error, 1);
    idle_bus();
    step();

    // Timeout with TIMEOUT_CYCLES=8
    req(4'b0000, 32'h6000_0100, 32'h0);
    step(); step(); step();
    n = 0;
    while (!cpu_ready && n < 40) begin
      step();
      n++;
    end
    chk("to_cycles", n, 8);
    chk("to_err", cpu_error, 1);
    chk("to_oe", nub_ad_oe, 0);
    idle_bus();
    step();

    // Unclaimed address
    req(4'b0000, 32'h5000_0000, 32'h0);
    #1 chk("unc_masterd", cpu_masterd_o, 0);
    n = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (arb_req_o || cpu_ready || !nub_startn_o) n++;
    end
    chk("unc_quiet", n, 0);
    idle_bus();
    step();

    // Reset during DATA of a write
    req(4'b1111, 32'h6000_0200, 32'h1234_5678);
    step(); step(); step();
    chk("rst_mid_oe_pre", nub_ad_oe, 1);
    reset = 1'b1;
    step();
    chk("rst_mid_ready", cpu_ready, 0);
    chk("rst_mid_arb", arb_req_o, 0);
    chk("rst_mid_oe", nub_ad_oe, 0);
    chk("rst_mid_ad", nub_ad_o, 0);
    reset = 1'b0;
    idle_bus();
    n = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (cpu_ready) n++;
    end
    chk("rst_mid_no_ready", n, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
